// File: rtl/uctl_fifo_drain_pkg.sv
// rtl/uctl_fifo_drain_pkg.sv - shared types, helpers and default widths for the FIFO drain arbiter
//
// Purpose: state encoding for the drain scheduler, a constant clog2 helper,
// and default parameter values with the widths derived from them.
// Ports: none (package).

package uctl_fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Ceiling log2, never less than 1 so that a 1-bit field is always legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int NUM_EP_DFLT    = 4;
  localparam int MAX_BURST_DFLT = 8;
  localparam int EP_W_DFLT      = clog2(NUM_EP_DFLT);
  localparam int LEN_W_DFLT     = clog2(MAX_BURST_DFLT + 1);

endpackage

// File: rtl/uctl_rr_pick.sv
// rtl/uctl_rr_pick.sv - combinational round-robin picker
//
// Purpose: returns the index of the first set request bit at or above ptr,
// wrapping around past N-1, plus a flag saying whether any bit was set.
// Ports:
//   req   in  N  request vector
//   ptr   in  W  search start index (must be < N)
//   idx   out W  index of the selected request (0 when none)
//   found out 1  at least one request bit was set

module uctl_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uctl_fifo_drain_arb.sv
// rtl/uctl_fifo_drain_arb.sv - round-robin burst drain of endpoint FIFOs into one stream
//
// Purpose: picks one eligible endpoint FIFO at a time, issues a credit-limited
// burst of read strobes sized from its fill level, and forwards the returned
// words through a 2-entry output buffer tagged with endpoint id and last flag.
// Ports:
//   clk, rst           clock (FIFO read clock) and async active-high reset
//   enable             allows new arbitration rounds
//   ep_flush           per-EP request to drain below the burst threshold
//   ep_empty           per-EP FIFO empty flags
//   ep_numOfData       packed per-EP fill levels
//   ep_dataOut         packed per-EP read data (1-cycle read latency)
//   ep_rdEn            one-hot read strobes
//   out_data/ep/last   output buffer head word, source EP, last-of-burst
//   out_valid/ready    output handshake
//   busy               scheduler active or buffer non-empty

module uctl_fifo_drain_arb
  import uctl_fifo_drain_pkg::*;
#(
  parameter  int NUM_EP        = NUM_EP_DFLT,
  parameter  int FIFO_ADDRSIZE = 4,
  parameter  int FIFO_DATASIZE = 32,
  parameter  int BURST_TH      = 4,
  parameter  int MAX_BURST     = MAX_BURST_DFLT,
  localparam int EP_W          = clog2(NUM_EP),
  localparam int LEN_W         = clog2(MAX_BURST + 1),
  localparam int NOD_W         = FIFO_ADDRSIZE + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_EP-1:0]                 ep_flush,
  input  logic [NUM_EP-1:0]                 ep_empty,
  input  logic [NUM_EP*NOD_W-1:0]           ep_numOfData,
  input  logic [NUM_EP*FIFO_DATASIZE-1:0]   ep_dataOut,
  output logic [NUM_EP-1:0]                 ep_rdEn,
  output logic [FIFO_DATASIZE-1:0]          out_data,
  output logic [EP_W-1:0]                   out_ep,
  output logic                              out_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy
);

  state_e              state;
  logic [EP_W-1:0]     rr_ptr;
  logic [EP_W-1:0]     grant;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    remaining;
  logic [LEN_W-1:0]    cap_idx;
  logic                rd_q;       // an rdEn was issued last cycle; its word arrives now

  logic [NOD_W-1:0]         nod_arr  [NUM_EP];
  logic [FIFO_DATASIZE-1:0] data_arr [NUM_EP];
  logic [NUM_EP-1:0]        elig;
  logic [EP_W-1:0]          pick_idx;
  logic                     pick_found;
  logic [NOD_W-1:0]         pick_nod;
  logic [LEN_W-1:0]         pick_len;

  logic [FIFO_DATASIZE-1:0] buf_data [2];
  logic [EP_W-1:0]          buf_ep   [2];
  logic                     buf_last [2];
  logic                     rd_ptr;
  logic                     wr_ptr;
  logic [1:0]               occ;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] credit;
  logic       push_last;

  // Unpack the per-EP buses and evaluate eligibility.
  always_comb begin
    for (int i = 0; i < NUM_EP; i++) begin
      nod_arr[i]  = ep_numOfData[i*NOD_W +: NOD_W];
      data_arr[i] = ep_dataOut[i*FIFO_DATASIZE +: FIFO_DATASIZE];
      elig[i]     = !ep_empty[i] && ((32'(nod_arr[i]) >= BURST_TH) || ep_flush[i]);
    end
  end

  uctl_rr_pick #(
    .N (NUM_EP),
    .W (EP_W)
  ) u_rr_pick (
    .req   (elig),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    pick_nod = nod_arr[pick_idx];
    if (32'(pick_nod) > MAX_BURST) pick_len = LEN_W'(MAX_BURST);
    else                           pick_len = LEN_W'(pick_nod);
  end

  assign pop       = out_valid && out_ready;
  assign push      = rd_q;
  assign push_last = (cap_idx == len - LEN_W'(1));

  // Credit check counts the entry leaving this cycle as already free, which
  // is what lets a read go out every cycle while out_ready stays high.
  always_comb begin
    credit  = 3'(occ) - 3'(pop) + 3'(rd_q) + 3'd1;
    issue   = (state == BURST) && (credit <= 3'd2);
    ep_rdEn = '0;
    if (issue) ep_rdEn[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      len       <= '0;
      remaining <= '0;
      cap_idx   <= '0;
      rd_q      <= 1'b0;
    end else begin
      rd_q <= issue;
      if (push) cap_idx <= cap_idx + LEN_W'(1);
      case (state)
        IDLE: begin
          if (enable && (|elig)) state <= ARB;
        end
        ARB: begin
          if (pick_found) begin
            grant     <= pick_idx;
            len       <= pick_len;
            remaining <= pick_len;
            cap_idx   <= '0;
            state     <= BURST;
          end else begin
            state <= IDLE;
          end
        end
        BURST: begin
          if (issue) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The final rdEn went out last cycle, so its word is captured on
          // this edge; the burst is fully accounted for.
          rr_ptr <= (32'(grant) == NUM_EP - 1) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_ep[i]   <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= data_arr[grant];
        buf_ep[wr_ptr]   <= grant;
        buf_last[wr_ptr] <= push_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_ep    = buf_ep[rd_ptr];
  assign out_last  = buf_last[rd_ptr];
  assign busy      = (state != IDLE) || (occ != 2'd0);

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && occ == 2'd2));

  a_no_read_empty : assert property (@(posedge clk) disable iff (rst)
    !(issue && ep_empty[grant]));

endmodule

// File: tb/tb_uctl_fifo_drain_arb.sv
// tb/tb_uctl_fifo_drain_arb.sv - scoreboard bench for uctl_fifo_drain_arb

module tb_uctl_fifo_drain_arb;
  import uctl_fifo_drain_pkg::*;

  localparam int NEP = 4;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int NW  = AW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NEP-1:0]    ep_flush;
  logic [NEP-1:0]    ep_empty;
  logic [NEP*NW-1:0] ep_numOfData;
  logic [NEP*DW-1:0] ep_dataOut;
  logic [NEP-1:0]    ep_rdEn;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_ep;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  always #5 clk = ~clk;

  uctl_fifo_drain_arb dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .ep_flush     (ep_flush),
    .ep_empty     (ep_empty),
    .ep_numOfData (ep_numOfData),
    .ep_dataOut   (ep_dataOut),
    .ep_rdEn      (ep_rdEn),
    .out_data     (out_data),
    .out_ep       (out_ep),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  // Endpoint FIFO models: 16-deep rings, 1-cycle read latency.
  logic [DW-1:0] mem [NEP][16];
  int            wr [NEP] = '{default: 0};
  int            rd [NEP] = '{default: 0};
  int            exp_seq [NEP] = '{default: 0};
  logic [DW-1:0] dout [NEP] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < NEP; i++) begin
      if (ep_rdEn[i]) begin
        dout[i] <= mem[i][rd[i] % 16];
        rd[i]   <= rd[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NEP; i++) begin
      ep_numOfData[i*NW +: NW] = NW'(wr[i] - rd[i]);
      ep_empty[i]              = (wr[i] == rd[i]);
      ep_dataOut[i*DW +: DW]   = dout[i];
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    ep;
    logic          last;
  } beat_t;

  beat_t      exp_q [$];
  logic [3:0] rd_hist [$];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int ep, input int seq);
    return {8'hA0 + 8'(ep), 24'(seq)};
  endfunction

  task automatic fill(input int ep, input int n);
    for (int k = 0; k < n; k++) begin
      mem[ep][wr[ep] % 16] = data_of(ep, wr[ep]);
      wr[ep]++;
    end
  endtask

  task automatic expect_burst(input int ep, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = data_of(ep, exp_seq[ep]);
      b.ep   = 2'(ep);
      b.last = (k == n - 1);
      exp_q.push_back(b);
      exp_seq[ep]++;
    end
  endtask

  // Inputs are set at the falling edge; sample 1ns later so the values seen
  // are exactly what the next rising edge acts on.
  task automatic step();
    beat_t b;
    #1;
    rd_hist.push_back(ep_rdEn);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'({out_last, out_ep, out_data}), 64'(0));
      end else begin
        b = exp_q.pop_front();
        check("beat", 64'({out_last, out_ep, out_data}), 64'({b.last, b.ep, b.data}));
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    check("drain_done", 64'({busy, exp_q.size() != 0}), 64'(0));
  endtask

  task automatic count_hist(input logic [3:0] mask, output int n);
    n = 0;
    foreach (rd_hist[k]) if ((rd_hist[k] & mask) != 4'd0) n++;
  endtask

  initial begin
    int n;
    logic [3:0] h;
    rst       = 1'b1;
    enable    = 1'b0;
    ep_flush  = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_rden",  64'(ep_rdEn),   64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data",  64'(out_data),  64'(0));
    check("rst_ep",    64'(out_ep),    64'(0));
    check("rst_last",  64'(out_last),  64'(0));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_rr",    64'(dut.rr_ptr), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Cap and fairness: every EP full, bursts of 8 in order 0,1,2,3 twice.
    for (int e = 0; e < NEP; e++) fill(e, 16);
    for (int r = 0; r < 2; r++)
      for (int e = 0; e < NEP; e++) expect_burst(e, 8);
    enable = 1'b1;
    wait_idle(400);
    check("fair_rr_wrap", 64'(dut.rr_ptr), 64'(0));

    // Single burst of 5 from EP1: one ARB cycle, then 5 back-to-back rdEn.
    rd_hist.delete();
    fill(1, 5);
    expect_burst(1, 5);
    wait_idle(60);
    for (int k = 0; k < 8; k++) begin
      h = (k < rd_hist.size()) ? rd_hist[k] : 4'hF;
      check("single_rden", 64'(h), 64'((k >= 2 && k <= 6) ? 4'b0010 : 4'b0000));
    end
    check("single_rr", 64'(dut.rr_ptr), 64'(2));

    // Below threshold: no grant without flush, 2-word burst with flush.
    rd_hist.delete();
    fill(2, 2);
    for (int k = 0; k < 12; k++) step();
    count_hist(4'hF, n);
    check("noflush_rden", 64'(n), 64'(0));
    check("noflush_busy", 64'(busy), 64'(0));
    ep_flush[2] = 1'b1;
    expect_burst(2, 2);
    wait_idle(40);
    ep_flush[2] = 1'b0;
    check("flush_rr", 64'(dut.rr_ptr), 64'(3));

    // Backpressure: 6-word burst from EP0 with out_ready low.
    rd_hist.delete();
    out_ready = 1'b0;
    fill(0, 6);
    expect_burst(0, 6);
    for (int k = 0; k < 10; k++) step();
    count_hist(4'b0001, n);
    check("bp_rden_cnt", 64'(n), 64'(2));
    check("bp_valid", 64'(out_valid), 64'(1));
    check("bp_head", 64'(out_data), 64'(data_of(0, exp_seq[0] - 6)));
    step();
    check("bp_hold", 64'({out_last, out_ep, out_data}), 64'({1'b0, 2'd0, data_of(0, exp_seq[0] - 6)}));
    for (int k = 0; k < 80 && (busy || exp_q.size() != 0); k++) begin
      out_ready = ~out_ready;
      step();
    end
    out_ready = 1'b1;
    wait_idle(20);
    count_hist(4'b0001, n);
    check("bp_rden_total", 64'(n), 64'(6));

    // Enable dropped mid-burst: EP1 finishes, EP2 stays unserved.
    rd_hist.delete();
    fill(1, 8);
    fill(2, 4);
    expect_burst(1, 8);
    for (int k = 0; k < 4; k++) step();
    enable = 1'b0;
    wait_idle(60);
    for (int k = 0; k < 10; k++) step();
    check("endrop_busy", 64'(busy), 64'(0));
    count_hist(4'b0100, n);
    check("endrop_no_ep2", 64'(n), 64'(0));
    count_hist(4'b0010, n);
    check("endrop_ep1_cnt", 64'(n), 64'(8));
    check("endrop_rr", 64'(dut.rr_ptr), 64'(2));

    // Reset in the middle of an EP2 burst.
    enable = 1'b1;
    expect_burst(2, 4);
    for (int k = 0; k < 4; k++) step();
    check("pre_rst_rden", 64'(ep_rdEn), 64'(4'b0100));
    rst    = 1'b1;
    enable = 1'b0;
    step();
    check("mid_rst_rden",  64'(ep_rdEn),    64'(0));
    check("mid_rst_valid", 64'(out_valid),  64'(0));
    check("mid_rst_state", 64'(dut.state),  64'(IDLE));
    check("mid_rst_rr",    64'(dut.rr_ptr), 64'(0));
    check("mid_rst_busy",  64'(busy),       64'(0));
    exp_q.delete();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
